execute_stage_p: RTL and testbench

Parametrised successor to the 16-bit execute stage. Accepts one decoded micro-op per handshake from operand fetch, performs ALU/MOV/load/store/push/pop/branch, keeps the NZCV flags and stack pointer internally, and hands results to writeback through a registered valid/ready output. Memory ops run a multi-cycle request/acknowledge FSM. Taken branches raise a one-cycle redirect to fetch.

---
 rtl/execute_stage_p.sv | 256 +++++++++++++++++++++++++
 tb/tb_execute_stage_p.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_p.sv
// Execute stage: ALU, MOV, load/store, push/pop and branch, with NZCV flags and stack pointer.
// Define EXEC_MUL_EN to enable the single-cycle MUL opcode (01000); otherwise 01000 is a NOP.
module execute_stage_p #(
   parameter int          DATA_W    = 16,
   parameter int          ADDR_W    = 16,
   parameter int          REG_IDX_W = 5,
   parameter logic [15:0] SP_RESET  = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           in_op,
   input  logic [DATA_W-1:0]    in_a,
   input  logic [DATA_W-1:0]    in_b,
   input  logic [REG_IDX_W-1:0] in_dst,
   input  logic [3:0]           in_cond,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_result,
   output logic [REG_IDX_W-1:0] out_dst,
   output logic                 out_wb_en,
   output logic [3:0]           out_nzcv,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_ack,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 br_en,
   output logic [ADDR_W-1:0]    br_target,
   output logic [ADDR_W-1:0]    sp,
   output logic [1:0]           o_dbg_state
);

   localparam int MSB = DATA_W - 1;
   localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_MUL  = 5'b01000;
   localparam logic [4:0] OP_CMP  = 5'b01111;
   localparam logic [4:0] OP_MOV  = 5'b10000;
   localparam logic [4:0] OP_LD   = 5'b10010;
   localparam logic [4:0] OP_ST   = 5'b10011;
   localparam logic [4:0] OP_PUSH = 5'b10110;
   localparam logic [4:0] OP_POP  = 5'b10111;
   localparam logic [4:0] OP_BR   = 5'b11000;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1} state_t;
   state_t r_state, w_state_next;

   logic                 r_out_valid, r_out_wb_en, r_br_en;
   logic [DATA_W-1:0]    r_out_result;
   logic [REG_IDX_W-1:0] r_out_dst;
   logic [3:0]           r_nzcv;
   logic                 r_mem_req, r_mem_we, r_is_push, r_is_pop;
   logic [ADDR_W-1:0]    r_mem_addr, r_br_target, r_sp;
   logic [DATA_W-1:0]    r_mem_wdata;

   logic w_accept, w_mem_done, w_cond_true;
   logic w_n, w_z, w_c_cur, w_v_cur;

   // Valid/ready: a micro-op transfers on a cycle where in_valid && in_ready; a result
   // transfers where out_valid && out_ready, and out_* hold steady until it does.
   assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_mem_done = (r_state == S_MEM) && mem_ack;

   assign {w_n, w_z, w_c_cur, w_v_cur} = r_nzcv;

   always_comb begin
      w_cond_true = 1'b0;
      case (in_cond)
         4'b0000: w_cond_true = 1'b1;
         4'b0001: w_cond_true = w_z;
         4'b0010: w_cond_true = !w_z;
         4'b0011: w_cond_true = w_c_cur;
         4'b0100: w_cond_true = !w_c_cur;
         4'b0101: w_cond_true = w_n;
         4'b0110: w_cond_true = !w_n;
         4'b0111: w_cond_true = w_v_cur;
         4'b1000: w_cond_true = !w_v_cur;
         4'b1001: w_cond_true = w_c_cur && !w_z;
         4'b1010: w_cond_true = !w_c_cur || w_z;
         4'b1011: w_cond_true = (w_n == w_v_cur);
         4'b1100: w_cond_true = (w_n != w_v_cur);
         4'b1101: w_cond_true = !w_z && (w_n == w_v_cur);
         4'b1110: w_cond_true = w_z || (w_n != w_v_cur);
         default: w_cond_true = 1'b0;
      endcase
   end

   logic [3:0]        w_amt;
   logic [DATA_W:0]   w_add, w_sub, w_shl, w_shr;
   assign w_amt = in_b[3:0];
   assign w_add = {1'b0, in_a} + {1'b0, in_b};
   assign w_sub = {1'b0, in_a} - {1'b0, in_b};
   // Extra bit catches the last bit shifted out: top bit for SHL, bottom bit for SHR.
   assign w_shl = {1'b0, in_a} << w_amt;
   assign w_shr = {in_a, 1'b0} >> w_amt;
`ifdef EXEC_MUL_EN
   logic [2*DATA_W-1:0] w_mul;
   assign w_mul = (2*DATA_W)'(in_a) * (2*DATA_W)'(in_b);
`endif

   logic [DATA_W-1:0] w_res, w_mem_wdata;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [3:0]        w_nzcv_next;
   logic w_c, w_v, w_upd, w_wb_en, w_is_mem, w_mem_we, w_is_push, w_is_pop, w_br_take;

   always_comb begin
      w_res       = '0;
      w_c         = w_c_cur;
      w_v         = w_v_cur;
      w_upd       = 1'b0;
      w_wb_en     = 1'b0;
      w_is_mem    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_is_push   = 1'b0;
      w_is_pop    = 1'b0;
      w_br_take   = 1'b0;
      case (in_op)
         OP_ADD: begin
            w_res = w_add[MSB:0]; w_c = w_add[DATA_W];
            w_v = (in_a[MSB] == in_b[MSB]) && (w_add[MSB] != in_a[MSB]);
            w_upd = 1'b1; w_wb_en = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            w_res = w_sub[MSB:0]; w_c = !w_sub[DATA_W];
            w_v = (in_a[MSB] != in_b[MSB]) && (w_sub[MSB] != in_a[MSB]);
            w_upd = 1'b1; w_wb_en = (in_op == OP_SUB);
         end
         OP_AND: begin w_res = in_a & in_b; w_upd = 1'b1; w_wb_en = 1'b1; end
         OP_OR:  begin w_res = in_a | in_b; w_upd = 1'b1; w_wb_en = 1'b1; end
         OP_XOR: begin w_res = in_a ^ in_b; w_upd = 1'b1; w_wb_en = 1'b1; end
         OP_SHL: begin
            w_res = w_shl[MSB:0];
            if (w_amt != 4'd0) w_c = w_shl[DATA_W];
            w_upd = 1'b1; w_wb_en = 1'b1;
         end
         OP_SHR: begin
            w_res = w_shr[DATA_W:1];
            if (w_amt != 4'd0) w_c = w_shr[0];
            w_upd = 1'b1; w_wb_en = 1'b1;
         end
`ifdef EXEC_MUL_EN
         OP_MUL: begin
            w_res = w_mul[MSB:0]; w_c = |w_mul[2*DATA_W-1:DATA_W];
            w_upd = 1'b1; w_wb_en = 1'b1;
         end
`endif
         OP_MOV: begin w_res = in_b; w_wb_en = 1'b1; end
         OP_LD: begin
            w_is_mem = 1'b1; w_mem_addr = ADDR_W'(in_b); w_wb_en = 1'b1;
         end
         OP_ST: begin
            w_is_mem = 1'b1; w_mem_we = 1'b1;
            w_mem_addr = ADDR_W'(in_b); w_mem_wdata = in_a;
         end
         OP_PUSH: begin
            w_is_mem = 1'b1; w_mem_we = 1'b1; w_is_push = 1'b1;
            w_mem_addr = r_sp - ADDR_W'(1); w_mem_wdata = in_b;
         end
         OP_POP: begin
            w_is_mem = 1'b1; w_is_pop = 1'b1; w_mem_addr = r_sp; w_wb_en = 1'b1;
         end
         OP_BR: w_br_take = w_cond_true;
         default: ;
      endcase
      w_nzcv_next = w_upd ? {w_res[MSB], (w_res == '0), w_c, w_v} : r_nzcv;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_is_mem) w_state_next = S_MEM;
         S_MEM:   if (mem_ack) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_dst    <= '0;
         r_out_wb_en  <= 1'b0;
         r_nzcv       <= 4'b0000;
         r_br_en      <= 1'b0;
         r_br_target  <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_is_push    <= 1'b0;
         r_is_pop     <= 1'b0;
         r_sp         <= SP_INIT;
      end else begin
         r_br_en <= 1'b0;
         if (r_out_valid && out_ready) r_out_valid <= 1'b0;
         if (w_accept) begin
            r_nzcv      <= w_nzcv_next;
            r_out_dst   <= in_dst;
            r_out_wb_en <= w_wb_en;
            if (w_is_mem) begin
               r_mem_req   <= 1'b1;
               r_mem_we    <= w_mem_we;
               r_mem_addr  <= w_mem_addr;
               r_mem_wdata <= w_mem_wdata;
               r_is_push   <= w_is_push;
               r_is_pop    <= w_is_pop;
            end else begin
               r_out_valid  <= 1'b1;
               r_out_result <= w_res;
               r_br_en      <= w_br_take;
               if (w_br_take) r_br_target <= ADDR_W'(in_a);
            end
         end
         if (w_mem_done) begin
            r_mem_req    <= 1'b0;
            r_out_valid  <= 1'b1;
            r_out_result <= r_mem_we ? r_mem_wdata : mem_rdata;
            if (r_is_push)     r_sp <= r_sp - ADDR_W'(1);
            else if (r_is_pop) r_sp <= r_sp + ADDR_W'(1);
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_dst     = r_out_dst;
   assign out_wb_en   = r_out_wb_en;
   assign out_nzcv    = r_nzcv;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign br_en       = r_br_en;
   assign br_target   = r_br_target;
   assign sp          = r_sp;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_execute_stage_p.sv
// Directed self-checking bench for execute_stage_p (default 16-bit configuration).
module tb_execute_stage_p;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [4:0]  in_op;
   logic [15:0] in_a, in_b;
   logic [4:0]  in_dst;
   logic [3:0]  in_cond;
   logic        out_valid, out_ready;
   logic [15:0] out_result;
   logic [4:0]  out_dst;
   logic        out_wb_en;
   logic [3:0]  out_nzcv;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        br_en;
   logic [15:0] br_target, sp;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;
   int n_out = 0;

   execute_stage_p dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .in_dst(in_dst), .in_cond(in_cond),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dst(out_dst),
      .out_wb_en(out_wb_en), .out_nzcv(out_nzcv),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .br_en(br_en), .br_target(br_target), .sp(sp), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (out_valid && out_ready) n_out++;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Driver: present one micro-op from a negedge, return at the negedge after it is accepted.
   task automatic send(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] dst, input logic [3:0] cond);
      int n;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dst = dst; in_cond = cond;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n >= 20) begin failures++; $display("FAIL send_accept got in_ready=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (sp !== 16'hFFFF) begin failures++; $display("FAIL rst_sp got=%h exp=ffff", sp); end
      checks++; if (out_nzcv !== 4'b0000) begin failures++; $display("FAIL rst_nzcv got=%b exp=0000", out_nzcv); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
      checks++; if (br_en !== 1'b0) begin failures++; $display("FAIL rst_br_en got=%b exp=0", br_en); end
      checks++; if (out_result !== 16'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", out_result); end
   endtask

   typedef struct packed {
      logic [4:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  nzcv;
      logic        wb;
   } alu_vec_t;

   task automatic test_alu();
      alu_vec_t tab [9];
      tab[0] = {5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1}; // ADD overflow
      tab[1] = {5'b00001, 16'h0005, 16'h0005, 16'h0000, 4'b0110, 1'b1}; // SUB to zero
      tab[2] = {5'b00010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0010, 1'b1}; // AND keeps C,V
      tab[3] = {5'b00110, 16'h4001, 16'h0001, 16'h8002, 4'b1000, 1'b1}; // SHL, C=0 out
      tab[4] = {5'b00111, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b1}; // SHR, C=1 out
      tab[5] = {5'b00100, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0110, 1'b1}; // XOR zero
      tab[6] = {5'b10000, 16'h0000, 16'hABCD, 16'hABCD, 4'b0110, 1'b1}; // MOV, flags kept
      tab[7] = {5'b00110, 16'h8000, 16'h0000, 16'h8000, 4'b1010, 1'b1}; // SHL by 0 keeps C
      tab[8] = {5'b00101, 16'h1234, 16'h5678, 16'h0000, 4'b1010, 1'b0}; // undefined op = NOP
      for (int i = 0; i < 9; i++) begin
         send(tab[i].op, tab[i].a, tab[i].b, 5'(i + 1), 4'h0);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL alu%0d_valid got=%b exp=1", i, out_valid); end
         checks++; if (out_nzcv !== tab[i].nzcv) begin failures++; $display("FAIL alu%0d_nzcv got=%b exp=%b", i, out_nzcv, tab[i].nzcv); end
         checks++; if (out_wb_en !== tab[i].wb) begin failures++; $display("FAIL alu%0d_wb_en got=%b exp=%b", i, out_wb_en, tab[i].wb); end
         checks++; if (out_dst !== 5'(i + 1)) begin failures++; $display("FAIL alu%0d_dst got=%0d exp=%0d", i, out_dst, i + 1); end
         if (tab[i].wb) begin
            checks++; if (out_result !== tab[i].res) begin failures++; $display("FAIL alu%0d_result got=%h exp=%h", i, out_result, tab[i].res); end
         end
      end
   endtask

   task automatic test_branch();
      send(5'b01111, 16'h0003, 16'h0005, 5'd0, 4'h0);
      checks++; if (out_nzcv !== 4'b1000) begin failures++; $display("FAIL cmp_nzcv got=%b exp=1000", out_nzcv); end
      checks++; if (out_wb_en !== 1'b0) begin failures++; $display("FAIL cmp_wb_en got=%b exp=0", out_wb_en); end
      send(5'b11000, 16'h0040, 16'h0000, 5'd0, 4'b1100);
      checks++; if (br_en !== 1'b1) begin failures++; $display("FAIL br_lt_en got=%b exp=1", br_en); end
      checks++; if (br_target !== 16'h0040) begin failures++; $display("FAIL br_lt_target got=%h exp=0040", br_target); end
      checks++; if (out_valid !== 1'b1 || out_wb_en !== 1'b0) begin failures++; $display("FAIL br_lt_out got=%b%b exp=10", out_valid, out_wb_en); end
      @(negedge clk);
      checks++; if (br_en !== 1'b0) begin failures++; $display("FAIL br_pulse_len got=%b exp=0", br_en); end
      send(5'b11000, 16'h0080, 16'h0000, 5'd0, 4'b1011);
      checks++; if (br_en !== 1'b0) begin failures++; $display("FAIL br_ge_en got=%b exp=0", br_en); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL br_ge_valid got=%b exp=1", out_valid); end
      send(5'b11000, 16'h1234, 16'h0000, 5'd0, 4'b0000);
      checks++; if (br_en !== 1'b1 || br_target !== 16'h1234) begin failures++; $display("FAIL br_al got=%b/%h exp=1/1234", br_en, br_target); end
      send(5'b11000, 16'h5678, 16'h0000, 5'd0, 4'b1111);
      checks++; if (br_en !== 1'b0) begin failures++; $display("FAIL br_nv_en got=%b exp=0", br_en); end
   endtask

   task automatic test_push_pop();
      send(5'b10110, 16'h0000, 16'hBEEF, 5'd0, 4'h0);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL push_req got=%b%b exp=11", mem_req, mem_we); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL push_in_ready got=%b exp=0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFE || mem_wdata !== 16'hBEEF) begin
            failures++; $display("FAIL push_hold%0d got=%b/%h/%h exp=1/fffe/beef", i, mem_req, mem_addr, mem_wdata); end
         if (i < 2) @(negedge clk);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL push_done got=%b%b exp=01", mem_req, out_valid); end
      checks++; if (out_wb_en !== 1'b0) begin failures++; $display("FAIL push_wb_en got=%b exp=0", out_wb_en); end
      checks++; if (sp !== 16'hFFFE) begin failures++; $display("FAIL push_sp got=%h exp=fffe", sp); end
      send(5'b10111, 16'h0000, 16'h0000, 5'd3, 4'h0);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'hFFFE) begin
         failures++; $display("FAIL pop_req got=%b/%b/%h exp=1/0/fffe", mem_req, mem_we, mem_addr); end
      mem_rdata = 16'hBEEF; mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 16'hBEEF) begin failures++; $display("FAIL pop_result got=%b/%h exp=1/beef", out_valid, out_result); end
      checks++; if (out_dst !== 5'd3 || out_wb_en !== 1'b1) begin failures++; $display("FAIL pop_dst got=%0d/%b exp=3/1", out_dst, out_wb_en); end
      checks++; if (sp !== 16'hFFFF) begin failures++; $display("FAIL pop_sp got=%h exp=ffff", sp); end
   endtask

   task automatic test_load_store();
      send(5'b10011, 16'h1111, 16'h0020, 5'd0, 4'h0);
      checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1111) begin
         failures++; $display("FAIL st_req got=%b/%h/%h exp=1/0020/1111", mem_we, mem_addr, mem_wdata); end
      mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_wb_en !== 1'b0) begin failures++; $display("FAIL st_done got=%b%b exp=10", out_valid, out_wb_en); end
      send(5'b10010, 16'h0000, 16'h0030, 5'd9, 4'h0);
      checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0030) begin failures++; $display("FAIL ld_req got=%b/%h exp=0/0030", mem_we, mem_addr); end
      mem_rdata = 16'h5A5A; mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
      checks++; if (out_result !== 16'h5A5A || out_wb_en !== 1'b1 || out_dst !== 5'd9) begin
         failures++; $display("FAIL ld_result got=%h/%b/%0d exp=5a5a/1/9", out_result, out_wb_en, out_dst); end
      checks++; if (sp !== 16'hFFFF) begin failures++; $display("FAIL ld_sp got=%h exp=ffff", sp); end
   endtask

   task automatic test_back_to_back();
      int n0;
      @(negedge clk);
      n0 = n_out;
      out_ready = 1'b0;
      send(5'b00000, 16'h0001, 16'h0002, 5'd4, 4'h0);
      in_valid = 1'b1; in_op = 5'b00000; in_a = 16'h0010; in_b = 16'h0020; in_dst = 5'd5;
      for (int i = 0; i < 4; i++) begin
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready got=%b exp=0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_result !== 16'h0003 || out_dst !== 5'd4) begin
            failures++; $display("FAIL bp%0d_hold got=%b/%h/%0d exp=1/0003/4", i, out_valid, out_result, out_dst); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 16'h0030 || out_dst !== 5'd5) begin
         failures++; $display("FAIL bp_second got=%b/%h/%0d exp=1/0030/5", out_valid, out_result, out_dst); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
      checks++; if (n_out - n0 !== 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", n_out - n0); end
   endtask

   task automatic test_mul();
      send(5'b00000, 16'h7FFF, 16'h0001, 5'd0, 4'h0);
      send(5'b01000, 16'h0100, 16'h0100, 5'd7, 4'h0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mul_valid got=%b exp=1", out_valid); end
`ifdef EXEC_MUL_EN
      checks++; if (out_result !== 16'h0000 || out_wb_en !== 1'b1) begin failures++; $display("FAIL mul_result got=%h/%b exp=0000/1", out_result, out_wb_en); end
      checks++; if (out_nzcv !== 4'b0111) begin failures++; $display("FAIL mul_nzcv got=%b exp=0111", out_nzcv); end
`else
      checks++; if (out_wb_en !== 1'b0) begin failures++; $display("FAIL mul_off_wb_en got=%b exp=0", out_wb_en); end
      checks++; if (out_nzcv !== 4'b1001) begin failures++; $display("FAIL mul_off_nzcv got=%b exp=1001", out_nzcv); end
`endif
   endtask

   task automatic test_reset_mid_mem();
      int n0;
      send(5'b10110, 16'h0000, 16'h0001, 5'd0, 4'h0);
      mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
      checks++; if (sp !== 16'hFFFE) begin failures++; $display("FAIL rmm_sp_pre got=%h exp=fffe", sp); end
      send(5'b10110, 16'h0000, 16'h0002, 5'd0, 4'h0);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFD) begin failures++; $display("FAIL rmm_req got=%b/%h exp=1/fffd", mem_req, mem_addr); end
      #2 reset = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmm_mem_req got=%b exp=0", mem_req); end
      checks++; if (sp !== 16'hFFFF) begin failures++; $display("FAIL rmm_sp got=%h exp=ffff", sp); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rmm_ready got=%b%b exp=10", in_ready, out_valid); end
      @(negedge clk);
      reset = 1'b1;
      n0 = n_out;
      mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || n_out !== n0) begin failures++; $display("FAIL rmm_late_ack got=%b/%0d exp=0/%0d", out_valid, n_out, n0); end
      checks++; if (sp !== 16'hFFFF || mem_req !== 1'b0) begin failures++; $display("FAIL rmm_after got=%h/%b exp=ffff/0", sp, mem_req); end
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_dst = '0; in_cond = '0;
      out_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_alu();
      test_branch();
      test_push_pop();
      test_load_store();
      test_back_to_back();
      test_mul();
      test_reset_mid_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
